cp0_reg: RTL and testbench
==========================

Name: cp0_reg

Overview:
- Coprocessor-0 register file and precise-exception commit unit; sits directly downstream of the MEM/WB pipeline register.
- Consumes that register's mtc0 write, c0 address/data, exception vector, branch-delay flag, eret and pc.
- Maintains BadVAddr/Count/Compare/Status/Cause/EPC, raises the timer interrupt, and produces the pipeline flush and redirect PC on exception or eret.

Parameters:
EXC_VECTOR, 32'hBFC00380, exception entry address (Status.BEV fixed 1)
COUNT_DIV, 2, clk cycles per Count increment (1 or 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
i_valid  in  1  WB slot holds a real instruction (0 for bubble/flush)
i_mtc0_we  in  1  mtc0 write enable
i_c0_addr  in  5  mtc0 destination register number
i_c0_wdata  in  32  mtc0 data
i_c0_raddr  in  5  mfc0 source register number
i_except  in  7  exception flags, bit0 AdEL-fetch, 1 RI, 2 Ov, 3 Syscall, 4 Break, 5 AdEL-data, 6 AdES
i_bad_addr  in  32  faulting address for AdEL/AdES
i_bd  in  1  instruction is in a branch delay slot
i_eret  in  1  eret commit
i_pc  in  32  pc of WB instruction
i_int  in  6  external hardware interrupts, level-sensitive
o_rdata  out  32  mfc0 read data
o_status  out  32  Status
o_cause  out  32  Cause
o_epc  out  32  EPC
o_timer_int  out  1  Cause.TI
o_flush  out  1  flush all pipeline registers (combinational)
o_new_pc  out  32  redirect target, valid when o_flush=1

Behaviour:
- Reset: BadVAddr=0, Count=0, Compare=0, Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, divider=0; o_flush=0, o_new_pc=0.
- Status writable bits: IM[15:8], EXL[1], IE[0]; others read 0 except BEV=1. Cause writable bits: IP[9:8] only. Count/Compare/EPC full 32-bit writable. BadVAddr read-only.
- Cause.IP[15:10] = {i_int[5] | TI, i_int[4:0]}, resampled every cycle.
- Count: increments by 1 every COUNT_DIV cycles (divider toggle), wraps 32'hFFFF_FFFF->0.
- TI: set the cycle after Count==Compare (Compare != 0), sticky; cleared by mtc0 Compare. An mtc0 Count takes priority over the increment that cycle.
- Interrupt pending: (Cause.IP & Status.IM) != 0 && IE && !EXL && i_valid.
- Exception priority, highest first: Int(0x00), AdEL-fetch(0x04), RI(0x0a), Ov(0x0c), Sys(0x08), Bp(0x09), AdEL-data(0x04), AdES(0x05). Exceptions are taken only when i_valid=1.
- Exception taken (same cycle, combinational): o_flush=1, o_new_pc=EXC_VECTOR.
- Exception taken (next edge):
  - ExcCode[6:2] updated; BadVAddr<=i_bad_addr for AdEL/AdES (i_pc for fetch AdEL).
  - If EXL was 0: EPC<=i_bd ? i_pc-4 : i_pc, Cause.BD<=i_bd. If EXL was already 1, EPC and BD are unchanged.
  - EXL<=1.
- eret (no exception): o_flush=1, o_new_pc=EPC (or i_c0_wdata if a same-cycle mtc0 EPC is pending); EXL<=0 on the edge.
- Update priority: exception > eret > mtc0. An mtc0 in an excepting instruction is suppressed.
- o_rdata: combinational read of i_c0_raddr; bypasses i_c0_wdata when i_mtc0_we && i_c0_addr==i_c0_raddr. Unimplemented numbers read 0.
- Reset mid-operation clears all state regardless of pending exception or eret.

Decomposition:
- Shared package/header: register numbers (8, 9, 11, 12, 13, 14), ExcCode constants, except-vector bit indices, EXC_VECTOR default.
- One natural sub-module: cp0_exc_prio (combinational priority encoder: i_except + int_pending -> take, excode).

Test Plan:
- Reset, then mfc0 12 -> 32'h0040_0000; mfc0 9 after 10 cycles (COUNT_DIV=2) -> 5.
- mtc0 Compare=8, Count=0 -> TI=1 and Cause[15]=1 after Count reaches 8; then mtc0 Compare=20 -> TI=0 next cycle.
- Status=32'h0040_8001 with TI pending and a valid instruction at pc 0x80001000 -> o_flush=1, o_new_pc=0xBFC00380; then EPC=0x80001000, EXL=1, ExcCode=0.
- i_except=bit2 (Ov), i_bd=1, pc=0x80000204 -> EPC=0x80000200, Cause.BD=1, ExcCode=0x0c. An AdES in the next instruction with EXL=1 leaves EPC unchanged, sets BadVAddr=i_bad_addr and ExcCode=0x05.
- eret with EPC=0x80000200 -> o_flush=1, o_new_pc=0x80000200, EXL=0 next cycle.
- Same cycle: RI flag with mtc0 Status=0 -> exception taken, Status.IM unchanged, ExcCode=0x0a.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// Shared constants for the CP0 register file: register numbers, ExcCodes,
// exception flag bit positions and the default exception entry address.
package cp0_reg_pkg;

  localparam logic [4:0] C0_BADVADDR = 5'd8;
  localparam logic [4:0] C0_COUNT    = 5'd9;
  localparam logic [4:0] C0_COMPARE  = 5'd11;
  localparam logic [4:0] C0_STATUS   = 5'd12;
  localparam logic [4:0] C0_CAUSE    = 5'd13;
  localparam logic [4:0] C0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int EX_ADEL_FETCH = 0;
  localparam int EX_RI         = 1;
  localparam int EX_OV         = 2;
  localparam int EX_SYS        = 3;
  localparam int EX_BP         = 4;
  localparam int EX_ADEL_DATA  = 5;
  localparam int EX_ADES       = 6;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RESET       = 32'h0040_0000;

  // Source BadVAddr is loaded from when an exception is taken.
  typedef enum logic [1:0] {
    BAD_NONE,
    BAD_PC,
    BAD_DATA
  } bad_sel_e;

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational exception priority encoder: picks the highest-priority cause
// in the WB slot and reports its ExcCode and BadVAddr source.
module cp0_exc_prio
  import cp0_reg_pkg::*;
(
  input  logic       valid,
  input  logic [6:0] except,
  input  logic       int_pending,
  output logic       take,
  output logic [4:0] excode,
  output bad_sel_e   bad_sel
);

  always_comb begin
    take    = 1'b0;
    excode  = EXC_INT;
    bad_sel = BAD_NONE;
    if (valid) begin
      take = 1'b1;
      if (int_pending)                 excode = EXC_INT;
      else if (except[EX_ADEL_FETCH]) begin
        excode  = EXC_ADEL;
        bad_sel = BAD_PC;
      end
      else if (except[EX_RI])          excode = EXC_RI;
      else if (except[EX_OV])          excode = EXC_OV;
      else if (except[EX_SYS])         excode = EXC_SYS;
      else if (except[EX_BP])          excode = EXC_BP;
      else if (except[EX_ADEL_DATA]) begin
        excode  = EXC_ADEL;
        bad_sel = BAD_DATA;
      end
      else if (except[EX_ADES]) begin
        excode  = EXC_ADES;
        bad_sel = BAD_DATA;
      end
      else                             take = 1'b0;
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file and precise-exception commit unit, fed by the
// MEM/WB pipeline register; generates flush and redirect PC.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic        i_mtc0_we,
  input  logic [4:0]  i_c0_addr,
  input  logic [31:0] i_c0_wdata,
  input  logic [4:0]  i_c0_raddr,
  input  logic [6:0]  i_except,
  input  logic [31:0] i_bad_addr,
  input  logic        i_bd,
  input  logic        i_eret,
  input  logic [31:0] i_pc,
  input  logic [5:0]  i_int,
  output logic [31:0] o_rdata,
  output logic [31:0] o_status,
  output logic [31:0] o_cause,
  output logic [31:0] o_epc,
  output logic        o_timer_int,
  output logic        o_flush,
  output logic [31:0] o_new_pc
);

  logic [31:0] bad_vaddr, count, compare, epc;
  logic [7:0]  im;
  logic        exl, ie, bd, ti, divider;
  logic [1:0]  ip_sw;
  logic [4:0]  excode;
  logic [5:0]  ip_hw;
  logic [7:0]  cause_ip;
  logic        int_pending, take, eret_take, mtc0_ok, count_tick;
  logic [4:0]  take_code;
  bad_sel_e    bad_sel;
  logic [31:0] epc_fwd;

  assign ip_hw       = {i_int[5] | ti, i_int[4:0]};
  assign cause_ip    = {ip_hw, ip_sw};
  assign int_pending = (|(cause_ip & im)) && ie && !exl;

  cp0_exc_prio u_prio (
    .valid       (i_valid),
    .except      (i_except),
    .int_pending (int_pending),
    .take        (take),
    .excode      (take_code),
    .bad_sel     (bad_sel)
  );

  // An excepting instruction never retires its mtc0 or eret.
  assign mtc0_ok    = i_valid && i_mtc0_we && !take;
  assign eret_take  = i_valid && i_eret && !take;
  assign count_tick = (COUNT_DIV == 1) ? 1'b1 : divider;
  assign epc_fwd    = (mtc0_ok && i_c0_addr == C0_EPC) ? i_c0_wdata : epc;

  assign o_flush  = !reset && (take || eret_take);
  assign o_new_pc = !o_flush ? 32'h0 : (take ? EXC_VECTOR : epc_fwd);

  assign o_status    = STATUS_RESET | {16'h0, im, 6'h0, exl, ie};
  assign o_cause     = {bd, 15'h0, cause_ip, 1'b0, excode, 2'b00};
  assign o_epc       = epc;
  assign o_timer_int = ti;

  // Later assignments in this block override earlier ones: exception > eret > mtc0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_vaddr <= '0;
      count     <= '0;
      compare   <= '0;
      epc       <= '0;
      im        <= '0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      bd        <= 1'b0;
      ti        <= 1'b0;
      ip_sw     <= '0;
      excode    <= '0;
      divider   <= 1'b0;
    end else begin
      divider <= ~divider;
      if (mtc0_ok && i_c0_addr == C0_COUNT) count <= i_c0_wdata;
      else if (count_tick)                  count <= count + 32'd1;
      if (mtc0_ok && i_c0_addr == C0_COMPARE) begin
        compare <= i_c0_wdata;
        ti      <= 1'b0;
      end else if (count == compare && compare != 32'h0) begin
        ti <= 1'b1;
      end
      if (mtc0_ok && i_c0_addr == C0_STATUS) begin
        im  <= i_c0_wdata[15:8];
        exl <= i_c0_wdata[1];
        ie  <= i_c0_wdata[0];
      end
      if (mtc0_ok && i_c0_addr == C0_CAUSE) ip_sw <= i_c0_wdata[9:8];
      if (mtc0_ok && i_c0_addr == C0_EPC)   epc   <= i_c0_wdata;
      if (eret_take) exl <= 1'b0;
      if (take) begin
        excode <= take_code;
        exl    <= 1'b1;
        if (!exl) begin
          epc <= i_bd ? i_pc - 32'd4 : i_pc;
          bd  <= i_bd;
        end
        case (bad_sel)
          BAD_PC:   bad_vaddr <= i_pc;
          BAD_DATA: bad_vaddr <= i_bad_addr;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata = 32'h0;
    if (i_mtc0_we && i_c0_addr == i_c0_raddr) o_rdata = i_c0_wdata;
    else begin
      case (i_c0_raddr)
        C0_BADVADDR: o_rdata = bad_vaddr;
        C0_COUNT:    o_rdata = count;
        C0_COMPARE:  o_rdata = compare;
        C0_STATUS:   o_rdata = o_status;
        C0_CAUSE:    o_rdata = o_cause;
        C0_EPC:      o_rdata = epc;
        default:     o_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_cp0_reg;

  logic        clk, reset;
  logic        i_valid, i_mtc0_we, i_bd, i_eret;
  logic [4:0]  i_c0_addr, i_c0_raddr;
  logic [31:0] i_c0_wdata, i_bad_addr, i_pc;
  logic [6:0]  i_except;
  logic [5:0]  i_int;
  logic [31:0] o_rdata, o_status, o_cause, o_epc, o_new_pc;
  logic        o_timer_int, o_flush;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];

  cp0_reg #(.EXC_VECTOR(VEC), .COUNT_DIV(2)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_mtc0_we(i_mtc0_we),
    .i_c0_addr(i_c0_addr), .i_c0_wdata(i_c0_wdata), .i_c0_raddr(i_c0_raddr),
    .i_except(i_except), .i_bad_addr(i_bad_addr), .i_bd(i_bd), .i_eret(i_eret),
    .i_pc(i_pc), .i_int(i_int), .o_rdata(o_rdata), .o_status(o_status),
    .o_cause(o_cause), .o_epc(o_epc), .o_timer_int(o_timer_int),
    .o_flush(o_flush), .o_new_pc(o_new_pc)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sample(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check_eq(tag, obs, 32'bx);
    else check_eq(tag, obs, exp_q.pop_front());
  endtask

  // Driver tasks: each starts and ends just after a falling edge.
  task automatic idle();
    i_valid = 0; i_mtc0_we = 0; i_c0_addr = 0; i_c0_wdata = 0; i_c0_raddr = 0;
    i_except = 0; i_bad_addr = 0; i_bd = 0; i_eret = 0; i_pc = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    i_c0_raddr = addr;
    expect_val(exp);
    #1 sample(tag, o_rdata);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    i_valid = 1; i_mtc0_we = 1; i_c0_addr = addr; i_c0_wdata = data;
    step(1);
    idle();
  endtask

  task automatic commit(input string tag, input logic [6:0] exc, input logic bd,
                        input logic eret, input logic [31:0] pc, input logic [31:0] bad,
                        input logic exp_flush, input logic [31:0] exp_pc);
    i_valid = 1; i_except = exc; i_bd = bd; i_eret = eret; i_pc = pc; i_bad_addr = bad;
    expect_val({31'h0, exp_flush});
    expect_val(exp_pc);
    #1;
    sample({tag, "_flush"}, {31'h0, o_flush});
    sample({tag, "_new_pc"}, o_new_pc);
    step(1);
    idle();
  endtask

  initial begin
    idle();
    i_int = 0;
    reset = 1;
    step(1);
    // Reset masks a pending exception on the flush outputs.
    i_valid = 1; i_except = 7'h04;
    expect_val(32'h0); expect_val(32'h0);
    #1;
    sample("rst_flush", {31'h0, o_flush});
    sample("rst_new_pc", o_new_pc);
    step(1);
    idle();
    reset = 0;
    rd("rst_status", 5'd12, 32'h0040_0000);
    step(10);
    rd("count_after_10", 5'd9, 32'd5);

    // Timer interrupt
    mtc0(5'd11, 32'd8);
    mtc0(5'd9, 32'd0);
    expect_val(32'h0);
    sample("ti_before", {31'h0, o_timer_int});
    for (int i = 0; i < 40 && !o_timer_int; i++) step(1);
    expect_val(32'h1);
    sample("ti_set", {31'h0, o_timer_int});
    rd("cause_ti", 5'd13, 32'h0000_8000);
    mtc0(5'd11, 32'd20);
    expect_val(32'h0);
    sample("ti_cleared", {31'h0, o_timer_int});
    mtc0(5'd9, 32'd20);
    for (int i = 0; i < 5 && !o_timer_int; i++) step(1);
    expect_val(32'h1);
    sample("ti_rearm", {31'h0, o_timer_int});

    // Interrupt taken
    mtc0(5'd12, 32'h0040_8001);
    commit("int", 7'h00, 0, 0, 32'h8000_1000, 32'h0, 1'b1, VEC);
    rd("int_epc", 5'd14, 32'h8000_1000);
    rd("int_status", 5'd12, 32'h0040_8003);
    rd("int_cause", 5'd13, 32'h0000_8000);
    mtc0(5'd11, 32'd0);
    commit("eret1", 7'h00, 0, 1, 32'h8000_2000, 32'h0, 1'b1, 32'h8000_1000);

    // Ov in delay slot, then AdES with EXL already set
    commit("ov", 7'h04, 1, 0, 32'h8000_0204, 32'h0, 1'b1, VEC);
    rd("ov_epc", 5'd14, 32'h8000_0200);
    rd("ov_cause", 5'd13, 32'h8000_0030);
    commit("ades", 7'h40, 0, 0, 32'h8000_0300, 32'h1234_5679, 1'b1, VEC);
    rd("ades_epc", 5'd14, 32'h8000_0200);
    rd("ades_badva", 5'd8, 32'h1234_5679);
    rd("ades_cause", 5'd13, 32'h8000_0014);
    commit("eret2", 7'h00, 0, 1, 32'h8000_0400, 32'h0, 1'b1, 32'h8000_0200);
    rd("eret2_status", 5'd12, 32'h0040_8001);

    // RI suppresses a same-instruction mtc0 Status
    i_mtc0_we = 1; i_c0_addr = 5'd12; i_c0_wdata = 32'h0;
    commit("ri", 7'h02, 0, 0, 32'h8000_0500, 32'h0, 1'b1, VEC);
    rd("ri_status", 5'd12, 32'h0040_8003);
    rd("ri_cause", 5'd13, 32'h0000_0028);

    // eret with same-cycle mtc0 EPC, plus mfc0 bypass
    i_mtc0_we = 1; i_c0_addr = 5'd14; i_c0_wdata = 32'h8000_4000;
    rd("bypass", 5'd14, 32'h8000_4000);
    commit("eret3", 7'h00, 0, 1, 32'h8000_0600, 32'h0, 1'b1, 32'h8000_4000);
    rd("unimpl", 5'd5, 32'h0);

    // Fetch AdEL outranks Ov; BadVAddr takes the pc
    commit("adel", 7'h05, 0, 0, 32'h8000_0700, 32'hAAAA_0000, 1'b1, VEC);
    rd("adel_badva", 5'd8, 32'h8000_0700);
    rd("adel_cause", 5'd13, 32'h0000_0010);
    rd("adel_epc", 5'd14, 32'h8000_0700);

    // Bubble never excepts
    i_except = 7'h04;
    expect_val(32'h0);
    #1 sample("bubble_flush", {31'h0, o_flush});
    idle();

    // Cause software bits and hardware lines
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_sw", 5'd13, 32'h0000_0310);
    i_int = 6'b100001;
    rd("cause_hw", 5'd13, 32'h0000_8710);
    i_int = 0;

    // Reset mid-operation
    reset = 1;
    i_valid = 1; i_except = 7'h02; i_eret = 1;
    expect_val(32'h0);
    #1 sample("mid_rst_flush", {31'h0, o_flush});
    step(1);
    idle();
    reset = 0;
    rd("mid_rst_epc", 5'd14, 32'h0);
    rd("mid_rst_status", 5'd12, 32'h0040_0000);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd("count_max", 5'd9, 32'hFFFF_FFFF);
    step(2);
    rd("count_wrap", 5'd9, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
